// File: rtl/rv_mem_bus_pkg.sv
// Shared types and helpers for the data-side memory bus.
package rv_bus_pkg;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic {IDLE, ACCESS} bus_state_t;

  localparam logic REGION_RAM = 1'b0;
  localparam logic REGION_IO  = 1'b1;

  // IO channel index taken from addr[3 +: clog2(nio)], at least one bit wide.
  function automatic int unsigned io_index(input logic [31:0] addr, input int unsigned nio);
    int unsigned idx_w;
    int unsigned mask;
    idx_w = (nio > 1) ? $clog2(nio) : 1;
    mask  = (32'd1 << idx_w) - 32'd1;
    return (addr >> 3) & mask;
  endfunction

endpackage

// File: rtl/rv_mem_bus_if.sv
// Core/DMemory side handshake bundle of rv_mem_bus.
interface rv_mem_bus_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_busy;
  logic        cpu_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wmask;
  logic [31:0] ram_rdata;

  // The bus block itself.
  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_wmask, ram_rdata,
    output cpu_rdata, cpu_done, cpu_busy, cpu_err, ram_addr, ram_wdata, ram_wmask
  );

  // The core plus DMemory surrounding the bus.
  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_wmask, ram_rdata,
    input  cpu_rdata, cpu_done, cpu_busy, cpu_err, ram_addr, ram_wdata, ram_wmask
  );
endinterface

// File: rtl/rv_mem_bus_io_reg_bank.sv
// Memory-mapped IO channels: byte-masked output registers, read mux, bad-index flag.
module io_reg_bank
  import rv_bus_pkg::*;
#(
  parameter int unsigned NUM_IO = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wmask,
  input  logic [NUM_IO*32-1:0] io_in,
  output logic [NUM_IO*32-1:0] io_out,
  output logic [31:0]          rdata,
  output logic                 bad_idx,
  output logic                 in_sel
);

  logic [31:0] io_q [NUM_IO];
  logic [31:0] io_d [NUM_IO];
  int unsigned idx;

  // Decode channel, flag out-of-range index, and mux read data.
  always_comb begin
    idx     = io_index(addr, NUM_IO);
    bad_idx = (idx >= NUM_IO);
    in_sel  = addr[2];
    rdata   = '0;
    for (int unsigned k = 0; k < NUM_IO; k++) begin
      if (k == idx) begin
        rdata = in_sel ? io_in[32*k +: 32] : io_q[k];
      end
    end
  end

  // Byte-masked update of the selected output register; input words are never written.
  always_comb begin
    for (int unsigned k = 0; k < NUM_IO; k++) begin
      io_d[k] = io_q[k];
    end
    if (wr_en && !bad_idx && !in_sel) begin
      for (int unsigned k = 0; k < NUM_IO; k++) begin
        if (k == idx) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (wmask[b]) begin
              io_d[k][8*b +: 8] = wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Output register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_IO; k++) begin
        io_q[k] <= '0;
      end
    end else begin
      io_q <= io_d;
    end
  end

  // Flatten output registers onto the pin bus.
  always_comb begin
    for (int unsigned k = 0; k < NUM_IO; k++) begin
      io_out[32*k +: 32] = io_q[k];
    end
  end

endmodule

// File: rtl/rv_mem_bus.sv
// Multi-cycle data bus: request latch, wait-state FSM, RAM drive and IO channels.
module rv_mem_bus
  import rv_bus_pkg::*;
#(
  parameter int unsigned NUM_IO     = 4,
  parameter int unsigned IO_SEL_BIT = 22,
  parameter int unsigned RAM_WAIT   = 1,
  parameter int unsigned IO_WAIT    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  rv_mem_bus_if.slave          bus,
  output logic [NUM_IO*32-1:0] io_out,
  input  logic [NUM_IO*32-1:0] io_in
);

  bus_state_t        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              region_q, region_d;

  logic        done;
  logic        io_wr;
  logic [31:0] io_rdata;
  logic        io_bad;
  logic        io_in_sel;

  // Next-state: accept in IDLE, count wait states down to zero in ACCESS.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    region_d = region_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d   = {bus.cpu_addr[31:2], 2'b00};
          wdata_d  = bus.cpu_wdata;
          wmask_d  = bus.cpu_wmask;
          region_d = bus.cpu_addr[IO_SEL_BIT];
          cnt_d    = bus.cpu_addr[IO_SEL_BIT] ? WAIT_W'(IO_WAIT) : WAIT_W'(RAM_WAIT);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      region_q <= REGION_RAM;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      region_q <= region_d;
    end
  end

  // Completion and bus outputs; done is masked by reset so an abandoned access never commits.
  always_comb begin
    done          = (state_q == ACCESS) && (cnt_q == '0) && !reset;
    io_wr         = done && (region_q == REGION_IO) && (wmask_q != '0);
    bus.cpu_done  = done;
    bus.cpu_busy  = (state_q != IDLE);
    bus.cpu_err   = done && (region_q == REGION_IO) &&
                    (io_bad || (io_in_sel && (wmask_q != '0)));
    bus.cpu_rdata = '0;
    if (done) begin
      bus.cpu_rdata = (region_q == REGION_RAM) ? bus.ram_rdata : io_rdata;
    end
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_wmask = '0;
    if ((state_q == ACCESS) && (region_q == REGION_RAM)) begin
      bus.ram_addr  = addr_q;
      bus.ram_wdata = wdata_q;
      bus.ram_wmask = done ? wmask_q : 4'b0000;
    end
  end

  io_reg_bank #(.NUM_IO(NUM_IO)) u_io (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (io_wr),
    .addr    (addr_q),
    .wdata   (wdata_q),
    .wmask   (wmask_q),
    .io_in   (io_in),
    .io_out  (io_out),
    .rdata   (io_rdata),
    .bad_idx (io_bad),
    .in_sel  (io_in_sel)
  );

endmodule

// File: tb/tb_rv_mem_bus.sv
// Directed self-checking bench for rv_mem_bus (two parameterisations).
module tb_rv_mem_bus;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  rv_mem_bus_if bus_a ();
  rv_mem_bus_if bus_b ();

  logic [127:0] io_out_a, io_in_a;
  logic [95:0]  io_out_b, io_in_b;

  rv_mem_bus #(.NUM_IO(4), .IO_SEL_BIT(22), .RAM_WAIT(2), .IO_WAIT(0)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a.slave), .io_out(io_out_a), .io_in(io_in_a)
  );

  rv_mem_bus #(.NUM_IO(3), .IO_SEL_BIT(22), .RAM_WAIT(3), .IO_WAIT(0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b.slave), .io_out(io_out_b), .io_in(io_in_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit b, input logic req, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask);
    if (!b) begin
      bus_a.cpu_req = req; bus_a.cpu_addr = addr; bus_a.cpu_wdata = wdata; bus_a.cpu_wmask = wmask;
    end else begin
      bus_b.cpu_req = req; bus_b.cpu_addr = addr; bus_b.cpu_wdata = wdata; bus_b.cpu_wmask = wmask;
    end
  endtask

  // Issue one access, hold req until done, report data/err/latency and any RAM write enables seen.
  task automatic xfer(input bit b, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wmask, output logic [31:0] rdata, output logic err,
                      output int lat, output logic [3:0] wm_or);
    logic got;
    got = 1'b0; lat = 0; wm_or = '0; rdata = '0; err = 1'b0;
    drive(b, 1'b1, addr, wdata, wmask);
    while (!got && lat < 20) begin
      tick();
      lat++;
      wm_or |= b ? bus_b.ram_wmask : bus_a.ram_wmask;
      if (b ? bus_b.cpu_done : bus_a.cpu_done) begin
        got   = 1'b1;
        rdata = b ? bus_b.cpu_rdata : bus_a.cpu_rdata;
        err   = b ? bus_b.cpu_err : bus_a.cpu_err;
      end
    end
    drive(b, 1'b0, '0, '0, '0);
    check("done_timeout", {31'b0, got}, 32'd1);
    tick();
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [3:0]  wm;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    bus_a.ram_rdata = 32'hCAFE_F00D;
    bus_b.ram_rdata = 32'h0BAD_0BAD;
    io_in_a = '0;
    io_in_b = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    tick(); tick();

    // Reset state
    check("rst_busy_a",  {31'b0, bus_a.cpu_busy}, 32'd0);
    check("rst_done_a",  {31'b0, bus_a.cpu_done}, 32'd0);
    check("rst_err_a",   {31'b0, bus_a.cpu_err}, 32'd0);
    check("rst_wmask_a", {28'b0, bus_a.ram_wmask}, 32'd0);
    check("rst_rdata_a", bus_a.cpu_rdata, 32'd0);
    check("rst_busy_b",  {31'b0, bus_b.cpu_busy}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Preload ch0 then reset for one cycle
    xfer(1'b0, 32'h0040_0000, 32'hCAFE_1234, 4'hF, rd, er, lat, wm);
    check("preload_ch0", io_out_a[31:0], 32'hCAFE_1234);
    rst_a = 1'b1;
    tick();
    check("rst1_io_ch0", io_out_a[31:0], 32'd0);
    check("rst1_busy",   {31'b0, bus_a.cpu_busy}, 32'd0);
    check("rst1_wmask",  {28'b0, bus_a.ram_wmask}, 32'd0);
    rst_a = 1'b0;

    // RAM store, RAM_WAIT=2: cycle-by-cycle
    drive(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    check("st_T_busy", {31'b0, bus_a.cpu_busy}, 32'd0);
    tick();
    check("st_T1_busy",  {31'b0, bus_a.cpu_busy}, 32'd1);
    check("st_T1_done",  {31'b0, bus_a.cpu_done}, 32'd0);
    check("st_T1_wmask", {28'b0, bus_a.ram_wmask}, 32'd0);
    check("st_T1_addr",  bus_a.ram_addr, 32'h0000_0100);
    check("st_T1_wdata", bus_a.ram_wdata, 32'hDEAD_BEEF);
    tick();
    check("st_T2_busy",  {31'b0, bus_a.cpu_busy}, 32'd1);
    check("st_T2_done",  {31'b0, bus_a.cpu_done}, 32'd0);
    check("st_T2_wmask", {28'b0, bus_a.ram_wmask}, 32'd0);
    tick();
    check("st_T3_busy",  {31'b0, bus_a.cpu_busy}, 32'd1);
    check("st_T3_done",  {31'b0, bus_a.cpu_done}, 32'd1);
    check("st_T3_wmask", {28'b0, bus_a.ram_wmask}, 32'h0000_000F);
    check("st_T3_err",   {31'b0, bus_a.cpu_err}, 32'd0);
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    check("st_T4_busy",  {31'b0, bus_a.cpu_busy}, 32'd0);
    check("st_T4_done",  {31'b0, bus_a.cpu_done}, 32'd0);
    check("st_T4_wmask", {28'b0, bus_a.ram_wmask}, 32'd0);
    check("st_T4_addr",  bus_a.ram_addr, 32'd0);

    // RAM load
    xfer(1'b0, 32'h0000_0200, 32'd0, 4'h0, rd, er, lat, wm);
    check("ramld_rdata", rd, 32'hCAFE_F00D);
    check("ramld_lat",   lat, 32'd3);
    check("ramld_wm",    {28'b0, wm}, 32'd0);

    // IO out register byte store / load, IO_WAIT=0
    xfer(1'b0, 32'h0040_0008, 32'h1122_3344, 4'hF, rd, er, lat, wm);
    xfer(1'b0, 32'h0040_0008, 32'h0000_00A5, 4'b0001, rd, er, lat, wm);
    check("io_st_lat",  lat, 32'd1);
    check("io_st_err",  {31'b0, er}, 32'd0);
    check("io_st_wm",   {28'b0, wm}, 32'd0);
    check("io_ch1_out", io_out_a[63:32], 32'h1122_33A5);
    xfer(1'b0, 32'h0040_0008, 32'd0, 4'h0, rd, er, lat, wm);
    check("io_ld_ch1",  rd, 32'h1122_33A5);
    xfer(1'b0, 32'h0070_0008, 32'd0, 4'h0, rd, er, lat, wm);
    check("io_alias_ch1", rd, 32'h1122_33A5);

    // IO input word: load ok, store rejected
    io_in_a[95:64] = 32'h1234_5678;
    xfer(1'b0, 32'h0040_0014, 32'd0, 4'h0, rd, er, lat, wm);
    check("in_ld_rdata", rd, 32'h1234_5678);
    check("in_ld_err",   {31'b0, er}, 32'd0);
    xfer(1'b0, 32'h0040_0014, 32'hFFFF_FFFF, 4'hF, rd, er, lat, wm);
    check("in_st_err",   {31'b0, er}, 32'd1);
    check("in_st_wm",    {28'b0, wm}, 32'd0);
    check("in_st_ch0",   io_out_a[31:0], 32'd0);
    check("in_st_ch1",   io_out_a[63:32], 32'h1122_33A5);
    check("in_st_ch2",   io_out_a[95:64], 32'd0);
    check("in_st_ch3",   io_out_a[127:96], 32'd0);

    // NUM_IO=3: index 3 is out of range
    xfer(1'b1, 32'h0040_0018, 32'd0, 4'h0, rd, er, lat, wm);
    check("bad_ld_rdata", rd, 32'd0);
    check("bad_ld_err",   {31'b0, er}, 32'd1);
    check("bad_ld_wm",    {28'b0, wm}, 32'd0);
    check("bad_ld_lat",   lat, 32'd1);
    xfer(1'b1, 32'h0040_0018, 32'hFFFF_FFFF, 4'hF, rd, er, lat, wm);
    check("bad_st_err",   {31'b0, er}, 32'd1);
    check("bad_st_wm",    {28'b0, wm}, 32'd0);
    check("bad_st_io",    io_out_b[31:0] | io_out_b[63:32] | io_out_b[95:64], 32'd0);
    xfer(1'b1, 32'h0040_0014, 32'd0, 4'h0, rd, er, lat, wm);
    check("b_in_ch2",     rd, 32'h3333_3333);

    // Reset during a RAM_WAIT=3 store
    drive(1'b1, 1'b1, 32'h0000_0300, 32'h55AA_55AA, 4'hF);
    tick();
    check("abort_T1_busy", {31'b0, bus_b.cpu_busy}, 32'd1);
    rst_b = 1'b1;
    drive(1'b1, 1'b0, '0, '0, '0);
    check("abort_T1_done",  {31'b0, bus_b.cpu_done}, 32'd0);
    check("abort_T1_wmask", {28'b0, bus_b.ram_wmask}, 32'd0);
    tick();
    rst_b = 1'b0;
    check("abort_busy",  {31'b0, bus_b.cpu_busy}, 32'd0);
    check("abort_done",  {31'b0, bus_b.cpu_done}, 32'd0);
    check("abort_wmask", {28'b0, bus_b.ram_wmask}, 32'd0);
    tick();
    check("abort_idle_done",  {31'b0, bus_b.cpu_done}, 32'd0);
    check("abort_idle_wmask", {28'b0, bus_b.ram_wmask}, 32'd0);
    xfer(1'b1, 32'h0000_0304, 32'h0102_0304, 4'hF, rd, er, lat, wm);
    check("fresh_lat", lat, 32'd4);
    check("fresh_wm",  {28'b0, wm}, 32'h0000_000F);
    check("fresh_err", {31'b0, er}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
